drive_ctrl: RTL and testbench
=============================

# drive_ctrl

Parametrised drive controller for the motor/dashboard datapath. It turns debounced accelerator and brake levels plus a gear index into a saturating speed level, using hold-to-repeat stepping, timed coasting and gradual overspeed decay after a downshift. It sits between the button debouncers and the PWM, servo-gauge and FND consumers. It supersedes the fixed-size pulse-driven RPM controller.

## Interface
Parameters:
- `LEVEL_W`, 4: width of `speed_level` and `max_level`.
- `GEAR_W`, 3: width of `gear`.
- `NUM_GEARS`, 5: highest valid gear index. Must be less than 2^GEAR_W.
- `GEAR_STEP`, 3: ceiling increment per gear.
- `ACCEL_STEP`, 1: level increase per accelerate step.
- `DECEL_STEP`, 2: level decrease per brake step.
- `REPEAT_DLY`, 4: ticks from press to first repeat. Must be ≥1.
- `REPEAT_RATE`, 2: ticks between subsequent repeats. Must be ≥1.
- `COAST_DIV`, 8: ticks per coast decrement. Must be ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  time-base strobe; all speed and counter activity is qualified by it.
- `accel`  in  1  debounced accelerator level.
- `decel`  in  1  debounced brake level.
- `gear`  in  GEAR_W  0 = neutral; 1..NUM_GEARS = valid gear; any larger value is treated as neutral.
- `speed_level`  out  LEVEL_W  current speed level.
- `max_level`  out  LEVEL_W  current gear ceiling.
- `state`  out  3  IDLE=0, ACCEL=1, BRAKE=2, COAST=3, LIMIT=4.
- `overspeed`  out  1  high while `state` is LIMIT.
- `level_changed`  out  1  one-cycle pulse after any change of `speed_level`.

## Operation
- **Ceiling:** `max_level` = min(gear × GEAR_STEP, 2^LEVEL_W − 1) for a valid gear, else 0. It is registered every `clk`, not only on `tick`.
- **Press and repeat:** `accel` and `decel` each pass through an edge/repeat unit sampled on `tick`.
  - A press is a tick sample of 1 following a tick sample of 0. A press produces a step immediately and loads the repeat counter with REPEAT_DLY.
  - While the button stays held, the counter decrements each tick. On expiry a step is produced and the counter reloads with REPEAT_RATE.
  - Result: steps fall at ticks 0, D, D+R, D+2R, …
- **Per-tick priority**, evaluated against the registered `max_level`:
  1. LIMIT when speed > max. Subtract DECEL_STEP if `decel` is held, else subtract 1. The result never goes below max or below 0. `accel` is ignored.
  2. BRAKE when `decel` is held (this includes `decel` and `accel` held together). On each decel step, subtract DECEL_STEP, saturating at 0.
  3. ACCEL when `accel` is held and speed < max. On each accel step, speed = min(speed + ACCEL_STEP, max).
  4. COAST when speed > 0. The coast counter counts ticks; every COAST_DIV ticks, subtract 1.
  5. IDLE otherwise.
- **Counter resets:** the coast counter clears whenever the state is not COAST. A button's repeat counter clears on release, and the accel repeat counter also clears while BRAKE pre-empts it.
- Holding `accel` at the ceiling selects COAST, not ACCEL: the state is COAST but no decay happens while accel is held; the coast counter stays cleared.
- Arithmetic uses LEVEL_W+1 bits internally, so there is no wrap-around.

## Timing
- Reset values: `speed_level`=0, `max_level`=0, `state`=IDLE, `overspeed`=0, `level_changed`=0. All counters and previous-sample registers are 0.
- `speed_level`, `state` and `overspeed` update in the cycle after the qualifying `tick`.
- `level_changed` asserts in the same cycle as the new `speed_level` and lasts exactly 1 cycle.
- A `gear` change reaches `max_level` 1 cycle later. Its first effect on speed is at the next `tick` after that.
- Reset asserted mid-operation: all outputs return to their reset values on the next edge. A button still held after reset is released counts as a new press on the first tick.
- `tick` held high continuously is legal: the block then runs one step evaluation per clock.

## Structure
- Package `drive_pkg` holds:
  - the `drive_state_t` enum (IDLE/ACCEL/BRAKE/COAST/LIMIT);
  - saturating add/subtract functions;
  - the parameter-legality check constants.
- Sub-module `hold_repeat`: edge detection and auto-repeat counter, with parameters REPEAT_DLY and REPEAT_RATE. There is one instance each for `accel` and `decel`.

## Test plan
Defaults throughout, `tick` high every cycle, and `gear`=3 (max 9) unless stated.
- Reset, then `accel` high for 1 tick → `speed_level`=1 and `level_changed` for 1 cycle; state ACCEL, then COAST.
- Hold `accel` for 20 ticks → steps at ticks 0, 4, 6, …, 18 reach 9; it then stays at 9 with state COAST and no decay.
- From speed 9, release all → 8 after 8 ticks; reaches 0 after 72 ticks total, then IDLE.
- `gear`=4 at speed 12, then `gear`=2 (max 6) → LIMIT with `overspeed`=1; 12→6 over 6 ticks, then COAST. `gear`=7 → `max_level`=0.
- Speed 7 with `accel` and `decel` both held → BRAKE: 5 at tick 0, 3 at tick 4, 1 at tick 6, 0 at tick 8 (saturated).
- Speed 5 with `accel` held, pulse `rst` → all outputs 0 next cycle; after reset is released, speed 1 on the first tick.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types, saturating helpers and parameter checks for drive_ctrl.
// Arithmetic helpers work in 32 bits so callers never see wrap-around.
package drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCEL = 3'd1,
        ST_BRAKE = 3'd2,
        ST_COAST = 3'd3,
        ST_LIMIT = 3'd4
    } drive_state_t;

    localparam int MIN_TICKS = 1;
    localparam int MAX_GEAR_W = 30;

    function automatic bit cfg_ok(
        input int lw,
        input int gw,
        input int ng,
        input int dly,
        input int rate,
        input int cdiv
    );
        return (lw >= 1) && (gw >= 1) && (gw <= MAX_GEAR_W)
            && (ng < (1 << gw))
            && (dly >= MIN_TICKS) && (rate >= MIN_TICKS)
            && (cdiv >= MIN_TICKS);
    endfunction

    function automatic logic [31:0] sat_sub(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] cap
    );
        logic [31:0] s;
        s = a + b;
        return (s > cap) ? cap : s;
    endfunction

endpackage

// File: rtl/drive_ctrl_if.sv
// Control inputs and dashboard outputs of the drive controller.
// The producer side (debouncers / bench) uses master, drive_ctrl uses slave.
interface drive_ctrl_if
    import drive_pkg::*;
#(
    parameter int LEVEL_W = 4,
    parameter int GEAR_W  = 3
) ();

    logic               tick;
    logic               accel;
    logic               decel;
    logic [GEAR_W-1:0]  gear;
    logic [LEVEL_W-1:0] speed_level;
    logic [LEVEL_W-1:0] max_level;
    drive_state_t       state;
    logic               overspeed;
    logic               level_changed;

    modport master (
        output tick, accel, decel, gear,
        input  speed_level, max_level, state, overspeed, level_changed
    );

    modport slave (
        input  tick, accel, decel, gear,
        output speed_level, max_level, state, overspeed, level_changed
    );

endinterface

// File: rtl/hold_repeat.sv
// Press detection with auto-repeat: steps at ticks 0, D, D+R, D+2R, ...
// A cleared counter while still held fires on the next uncleared tick.
module hold_repeat #(
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    input  logic i_clr,
    output logic o_step
);

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_expire;

    always_comb begin
        w_press   = i_btn && !r_prev;
        w_expire  = i_btn && r_prev && (r_cnt <= CNT_W'(1));
        o_step    = i_tick && (w_press || w_expire);
        w_cnt_nxt = r_cnt;
        if (!i_btn || i_clr) begin
            w_cnt_nxt = '0;
        end else if (w_press) begin
            w_cnt_nxt = CNT_W'(REPEAT_DLY);
        end else if (w_expire) begin
            w_cnt_nxt = CNT_W'(REPEAT_RATE);
        end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else if (i_tick) begin
            r_prev <= i_btn;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/drive_ctrl.sv
// Drive controller: gear ceiling, hold-to-repeat accel/brake, timed coast
// and gradual overspeed decay, all stepping on the tick strobe.
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int LEVEL_W     = 4,
    parameter int GEAR_W      = 3,
    parameter int NUM_GEARS   = 5,
    parameter int GEAR_STEP   = 3,
    parameter int ACCEL_STEP  = 1,
    parameter int DECEL_STEP  = 2,
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 2,
    parameter int COAST_DIV   = 8
) (
    input logic        clk,
    input logic        rst,
    drive_ctrl_if.slave bus
);

    localparam int XW     = LEVEL_W + 1;
    localparam int CW     = (COAST_DIV > 1) ? $clog2(COAST_DIV) : 1;
    localparam int LVLTOP = (1 << LEVEL_W) - 1;

    if (!cfg_ok(LEVEL_W, GEAR_W, NUM_GEARS, REPEAT_DLY, REPEAT_RATE, COAST_DIV))
    begin : g_bad_cfg
        $error("drive_ctrl: illegal parameter set");
    end

    drive_state_t       r_state;
    drive_state_t       w_state_nxt;
    logic [LEVEL_W-1:0] r_speed;
    logic [LEVEL_W-1:0] r_max;
    logic [CW-1:0]      r_coast;
    logic [CW-1:0]      w_coast_nxt;
    logic               r_chg;

    logic [XW-1:0]      w_spd;
    logic [XW-1:0]      w_max;
    logic [XW-1:0]      w_spd_nxt;
    logic [31:0]        w_prod;
    logic [31:0]        w_sub;
    logic [LEVEL_W-1:0] w_ceil;
    logic               w_over;
    logic               w_brake;
    logic               w_acc;
    logic               w_cst;
    logic               w_astep;
    logic               w_dstep;

    hold_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
    ) u_accel (
        .clk   (clk),
        .rst   (rst),
        .i_tick(bus.tick),
        .i_btn (bus.accel),
        .i_clr (w_brake),
        .o_step(w_astep)
    );

    hold_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
    ) u_decel (
        .clk   (clk),
        .rst   (rst),
        .i_tick(bus.tick),
        .i_btn (bus.decel),
        .i_clr (1'b0),
        .o_step(w_dstep)
    );

    // Out-of-range gear indices behave as neutral.
    always_comb begin
        w_prod = 32'(bus.gear) * 32'(GEAR_STEP);
        w_ceil = '0;
        if ((bus.gear != '0) && (32'(bus.gear) <= 32'(NUM_GEARS))) begin
            w_ceil = (w_prod > 32'(LVLTOP)) ? LEVEL_W'(LVLTOP) : LEVEL_W'(w_prod);
        end
    end

    assign w_spd   = {1'b0, r_speed};
    assign w_max   = {1'b0, r_max};
    assign w_over  = w_spd > w_max;
    assign w_brake = !w_over && bus.decel;
    assign w_acc   = !w_over && !bus.decel && bus.accel && (w_spd < w_max);
    assign w_cst   = !w_over && !bus.decel && !w_acc && (w_spd != '0);

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_spd_nxt   = w_spd;
        w_coast_nxt = '0;
        w_sub       = '0;
        unique case (1'b1)
            w_over: begin
                w_state_nxt = ST_LIMIT;
                w_sub = sat_sub(32'(w_spd), bus.decel ? 32'(DECEL_STEP) : 32'd1);
                w_spd_nxt = (w_sub < 32'(w_max)) ? w_max : XW'(w_sub);
            end
            w_brake: begin
                w_state_nxt = ST_BRAKE;
                if (w_dstep) begin
                    w_spd_nxt = XW'(sat_sub(32'(w_spd), 32'(DECEL_STEP)));
                end
            end
            w_acc: begin
                w_state_nxt = ST_ACCEL;
                if (w_astep) begin
                    w_spd_nxt = XW'(sat_add(32'(w_spd), 32'(ACCEL_STEP), 32'(w_max)));
                end
            end
            w_cst: begin
                w_state_nxt = ST_COAST;
                // Holding accel at the ceiling parks here without decay.
                if (!bus.accel) begin
                    if (r_coast == CW'(COAST_DIV - 1)) begin
                        w_spd_nxt = w_spd - XW'(1);
                    end else begin
                        w_coast_nxt = r_coast + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_speed <= '0;
            r_max   <= '0;
            r_coast <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_max <= w_ceil;
            r_chg <= 1'b0;
            if (bus.tick) begin
                r_state <= w_state_nxt;
                r_speed <= LEVEL_W'(w_spd_nxt);
                r_coast <= w_coast_nxt;
                r_chg   <= (LEVEL_W'(w_spd_nxt) != r_speed);
            end
        end
    end

    assign bus.speed_level   = r_speed;
    assign bus.max_level     = r_max;
    assign bus.state         = r_state;
    assign bus.overspeed     = (r_state == ST_LIMIT);
    assign bus.level_changed = r_chg;

endmodule

// File: tb/tb_drive_ctrl.sv
// Directed bench for drive_ctrl: tick-indexed behavioural model compared
// every cycle, plus hand-computed milestones from the usage scenarios.
module tb_drive_ctrl;
    import drive_pkg::*;

    localparam int LW = 4;
    localparam int GW = 3;
    localparam int NG = 5;
    localparam int GS = 3;
    localparam int AS = 1;
    localparam int DS = 2;
    localparam int D  = 4;
    localparam int R  = 2;
    localparam int CD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drive_ctrl_if #(.LEVEL_W(LW), .GEAR_W(GW)) bus ();

    drive_ctrl #(
        .LEVEL_W(LW), .GEAR_W(GW), .NUM_GEARS(NG), .GEAR_STEP(GS),
        .ACCEL_STEP(AS), .DECEL_STEP(DS), .REPEAT_DLY(D),
        .REPEAT_RATE(R), .COAST_DIV(CD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ceil_of(input int g);
        if (g >= 1 && g <= NG) return (g * GS > 15) ? 15 : g * GS;
        return 0;
    endfunction

    // Model: steps are scheduled by absolute tick index, not by countdowns.
    int m_speed, m_max, m_state, m_chg, m_coast, now;
    int a_next, d_next;
    bit a_prev, d_prev;

    initial begin
        m_speed = 0; m_max = 0; m_state = 0; m_chg = 0; m_coast = 0;
        now = 0; a_next = 0; d_next = 0; a_prev = 0; d_prev = 0;
    end

    always @(posedge clk) begin : model
        int nsp, nst;
        bit ast, dst;
        if (rst) begin
            m_speed = 0; m_max = 0; m_state = 0; m_chg = 0; m_coast = 0;
            a_prev = 0; d_prev = 0;
        end else begin
            m_chg = 0;
            if (bus.tick) begin
                ast = 0;
                dst = 0;
                if (bus.accel) begin
                    if (!a_prev) begin ast = 1; a_next = now + D; end
                    else if (now >= a_next) begin ast = 1; a_next = now + R; end
                end
                if (bus.decel) begin
                    if (!d_prev) begin dst = 1; d_next = now + D; end
                    else if (now >= d_next) begin dst = 1; d_next = now + R; end
                end
                a_prev = bus.accel;
                d_prev = bus.decel;
                nsp = m_speed;
                if (m_speed > m_max) begin
                    nst = 4;
                    nsp = m_speed - (bus.decel ? DS : 1);
                    if (nsp < m_max) nsp = m_max;
                    if (nsp < 0) nsp = 0;
                    m_coast = 0;
                end else if (bus.decel) begin
                    nst = 2;
                    if (dst) nsp = (m_speed > DS) ? m_speed - DS : 0;
                    m_coast = 0;
                    if (bus.accel) a_next = now + 1;
                end else if (bus.accel && m_speed < m_max) begin
                    nst = 1;
                    if (ast) nsp = (m_speed + AS > m_max) ? m_max : m_speed + AS;
                    m_coast = 0;
                end else if (m_speed > 0) begin
                    nst = 3;
                    if (bus.accel) m_coast = 0;
                    else begin
                        m_coast++;
                        if (m_coast == CD) begin nsp = m_speed - 1; m_coast = 0; end
                    end
                end else begin
                    nst = 0;
                    m_coast = 0;
                end
                m_chg = (nsp != m_speed) ? 1 : 0;
                m_speed = nsp;
                m_state = nst;
                now++;
            end
            m_max = ceil_of(int'(bus.gear));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("speed_level", int'(bus.speed_level), m_speed);
            chk("max_level", int'(bus.max_level), m_max);
            chk("state", int'(bus.state), m_state);
            chk("overspeed", int'(bus.overspeed), (m_state == 4) ? 1 : 0);
            chk("level_changed", int'(bus.level_changed), m_chg);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.tick = 1'b1;
        bus.accel = 1'b0;
        bus.decel = 1'b0;
        bus.gear = 3'd3;
        cyc(2);
        cmp_en = 1'b1;
        chk("rst_speed", int'(bus.speed_level), 0);
        chk("rst_max", int'(bus.max_level), 0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_lc", int'(bus.level_changed), 0);
        rst = 1'b0;
        cyc(1);
        chk("gear3_max", int'(bus.max_level), 9);

        bus.accel = 1'b1; cyc(1);
        chk("tap_speed", int'(bus.speed_level), 1);
        chk("tap_lc", int'(bus.level_changed), 1);
        chk("tap_state", int'(bus.state), 1);
        bus.accel = 1'b0; cyc(1);
        chk("tap_coast", int'(bus.state), 3);
        chk("tap_lc_end", int'(bus.level_changed), 0);

        bus.accel = 1'b1; cyc(20);
        chk("hold_speed", int'(bus.speed_level), 9);
        chk("hold_state", int'(bus.state), 3);
        cyc(10);
        chk("hold_nodecay", int'(bus.speed_level), 9);
        bus.accel = 1'b0; cyc(7);
        chk("coast_7", int'(bus.speed_level), 9);
        cyc(1);
        chk("coast_8", int'(bus.speed_level), 8);
        cyc(63);
        chk("coast_71", int'(bus.speed_level), 1);
        cyc(1);
        chk("coast_72", int'(bus.speed_level), 0);
        chk("coast_72_state", int'(bus.state), 3);
        cyc(1);
        chk("coast_idle", int'(bus.state), 0);

        bus.gear = 3'd4; bus.accel = 1'b1; cyc(26);
        chk("g4_speed", int'(bus.speed_level), 12);
        chk("g4_max", int'(bus.max_level), 12);
        bus.accel = 1'b0; bus.gear = 3'd2; cyc(1);
        chk("g2_max", int'(bus.max_level), 6);
        chk("g2_first_state", int'(bus.state), 3);
        cyc(1);
        chk("limit_state", int'(bus.state), 4);
        chk("limit_ovs", int'(bus.overspeed), 1);
        chk("limit_speed", int'(bus.speed_level), 11);
        cyc(5);
        chk("limit_end_speed", int'(bus.speed_level), 6);
        chk("limit_end_state", int'(bus.state), 4);
        cyc(1);
        chk("limit_exit_state", int'(bus.state), 3);
        chk("limit_exit_ovs", int'(bus.overspeed), 0);
        bus.gear = 3'd7; cyc(1);
        chk("gear7_max", int'(bus.max_level), 0);
        cyc(8);
        chk("gear7_speed", int'(bus.speed_level), 0);
        chk("gear7_state", int'(bus.state), 0);

        bus.gear = 3'd3; cyc(1);
        bus.accel = 1'b1; cyc(15);
        chk("pre_brake", int'(bus.speed_level), 7);
        bus.decel = 1'b1; cyc(1);
        chk("brake_t0", int'(bus.speed_level), 5);
        chk("brake_state", int'(bus.state), 2);
        cyc(3);
        chk("brake_t3", int'(bus.speed_level), 5);
        cyc(1);
        chk("brake_t4", int'(bus.speed_level), 3);
        cyc(2);
        chk("brake_t6", int'(bus.speed_level), 1);
        cyc(2);
        chk("brake_t8", int'(bus.speed_level), 0);
        bus.accel = 1'b0; bus.decel = 1'b0; cyc(2);

        bus.accel = 1'b1; cyc(11);
        chk("pre_rst", int'(bus.speed_level), 5);
        rst = 1'b1; cyc(1);
        chk("mid_rst_speed", int'(bus.speed_level), 0);
        chk("mid_rst_max", int'(bus.max_level), 0);
        chk("mid_rst_state", int'(bus.state), 0);
        chk("mid_rst_lc", int'(bus.level_changed), 0);
        rst = 1'b0; bus.tick = 1'b0; cyc(1);
        chk("post_rst_notick", int'(bus.speed_level), 0);
        bus.tick = 1'b1; cyc(1);
        chk("post_rst_speed", int'(bus.speed_level), 1);
        chk("post_rst_lc", int'(bus.level_changed), 1);
        bus.accel = 1'b0; cyc(3);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
